alarm_time_set: RTL and testbench
=================================

# alarm_time_set

Push-button alarm-time entry stage that produces the `alarm_hr` / `alarm_min` values consumed by the clock/alarm comparator.
- Three raw mechanical buttons (mode, up, down) are synchronised, debounced and edge-detected.
- A three-state editor FSM steps the hour (mod 24) or minute (mod 60) field.
- Sits between the board push-buttons and the alarm comparator; outputs are registered and hold steady between edits.

## Interface
- `DEBOUNCE_CYC`, 1_000_000: consecutive stable cycles required to accept a button level change (20 ms at 50 MHz).
- `REPEAT_DELAY_CYC`, 25_000_000: hold time before the first auto-repeat step (0.5 s).
- `REPEAT_RATE_CYC`, 5_000_000: period between auto-repeat steps (0.1 s).
- `RST_HR`, 7: hour value loaded at reset, 0..23.
- `RST_MIN`, 0: minute value loaded at reset, 0..59.
- `clk`  in  1  system clock; the single clock for the whole block.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_mode`  in  1  raw mode button, asynchronous, active-high.
- `btn_up`  in  1  raw increment button, asynchronous, active-high.
- `btn_down`  in  1  raw decrement button, asynchronous, active-high.
- `alarm_hr`  out  5  alarm hour, 0..23, registered.
- `alarm_min`  out  6  alarm minute, 0..59, registered.
- `edit_hr`  out  1  high while in state SET_HR.
- `edit_min`  out  1  high while in state SET_MIN.
- `alarm_valid`  out  1  high only in state RUN; the downstream comparator gates on it.

## Operation
- Input conditioning, per button:
  - 2-flop synchroniser.
  - Debounce counter: counts cycles where the synced level ≠ the debounced level; clears whenever they are equal; on reaching `DEBOUNCE_CYC`, the debounced level flips and the counter clears.
  - Press event: one-cycle pulse on a 0→1 transition of the debounced level. Releases generate no event.
- FSM states: RUN, SET_HR, SET_MIN.
  - A mode event advances RUN→SET_HR→SET_MIN→RUN.
  - Up/down events are ignored in RUN.
- Field arithmetic:
  - SET_HR: up gives hr+1, with 23→0; down gives hr−1, with 0→23.
  - SET_MIN: same rule mod 60 (59→0, 0→59).
  - Fields never hold out-of-range values.
- Simultaneous events:
  - Mode with up/down in the same cycle: the mode transition is taken and the step is dropped.
  - Up and down in the same cycle: both are dropped.
- The field not being edited is never modified.
- Leaving SET_MIN keeps the edited values. Only reset restores `RST_HR` / `RST_MIN`.

## Timing
- Reset values:
  - FSM = RUN.
  - `alarm_hr` = `RST_HR`, `alarm_min` = `RST_MIN`.
  - `edit_hr` = 0, `edit_min` = 0, `alarm_valid` = 1.
  - All synchronisers, debounced levels and counters = 0.
- Latency: a raw button first sampled high at edge N and held updates the field (or FSM state) at edge N+`DEBOUNCE_CYC`+2. `edit_*` and `alarm_valid` change at that same edge.
- Glitches shorter than `DEBOUNCE_CYC` cycles produce no event.
- Reset asserted mid-edit:
  - Applies at the next edge: back to RUN with reset values.
  - Buttons still held after reset release must see a fresh 0→1 debounced transition; the debounced state restarts at 0, so a held button registers after debounce.

## Configuration
- Macro: `ALARM_SET_AUTOREPEAT_EN`.
- Defined:
  - In SET_HR/SET_MIN, holding up (or down) alone for `REPEAT_DELAY_CYC` cycles after its press event produces an extra step.
  - Further steps follow every `REPEAT_RATE_CYC` cycles while the button is held.
  - Repeat stops on release, on a mode event, or if the opposite button becomes debounced-high.
  - After a mode change, a still-held button does not step the new field until it is released and pressed again.
- Undefined: exactly one step per press event; no repeat counters are synthesised.

## Test plan
Bench parameters: `DEBOUNCE_CYC`=4, `REPEAT_DELAY_CYC`=20, `REPEAT_RATE_CYC`=5.
- Reset: assert `rst` 1 cycle → `alarm_hr`=7, `alarm_min`=0, `alarm_valid`=1, `edit_hr`=`edit_min`=0.
- Glitch rejection: 3-cycle pulse on `btn_mode` → no state change. 10-cycle press → SET_HR and `alarm_valid`=0 exactly 6 edges after the first sample.
- Wrap: in SET_HR from 23, one up press → 0. In SET_MIN from 0, one down press → 59. `alarm_hr` is unchanged during minute edits.
- Simultaneity:
  - up+down pressed together in SET_HR at 7 → stays 7.
  - mode+up together in SET_HR → SET_MIN entered, hr still 7, min unchanged.
- Auto-repeat, macro defined: hold up 40 cycles after its event in SET_MIN from 10 → steps at event, +20, +25, +30, +35, +40 → 16.
- Auto-repeat, macro undefined: same stimulus → min = 11.
- Reset mid-edit: in SET_MIN with min=42, pulse `rst` → RUN, 07:00, `alarm_valid`=1.

Source files
------------

// File: rtl/alarm_time_set.sv
// Push-button alarm-time editor: synchronises, debounces and edge-detects three
// buttons and steps the alarm hour/minute fields. Optional auto-repeat: ALARM_SET_AUTOREPEAT_EN.
module alarm_time_set #(
    parameter int DEBOUNCE_CYC     = 1_000_000,
    parameter int REPEAT_DELAY_CYC = 25_000_000,
    parameter int REPEAT_RATE_CYC  = 5_000_000,
    parameter int RST_HR           = 7,
    parameter int RST_MIN          = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [4:0] alarm_hr,
    output logic [5:0] alarm_min,
    output logic       edit_hr,
    output logic       edit_min,
    output logic       alarm_valid
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_t;

    // Bit order of the button vectors: [0] mode, [1] up, [2] down.
    logic [2:0]            btn_raw_s;
    logic [2:0]            sync1_q;
    logic [2:0]            sync2_q;
    logic [2:0]            deb_q;
    logic [2:0]            deb_prev_q;
    logic [2:0][DB_W-1:0]  db_cnt_q;
    logic [2:0]            press_ev_s;

    state_t     state_q;
    logic [4:0] hr_q;
    logic [5:0] min_q;
    logic       edit_hr_q;
    logic       edit_min_q;
    logic       valid_q;

    logic       mode_ev_s;
    logic       step_up_s;
    logic       step_dn_s;
    logic       rpt_up_s;
    logic       rpt_dn_s;
    logic       inc_s;
    logic       dec_s;

    function automatic logic [4:0] hr_step(input logic [4:0] v, input logic up);
        if (up) begin
            return (v >= 5'd23) ? 5'd0 : v + 5'd1;
        end else begin
            return (v == 5'd0 || v > 5'd23) ? 5'd23 : v - 5'd1;
        end
    endfunction

    function automatic logic [5:0] min_step(input logic [5:0] v, input logic up);
        if (up) begin
            return (v >= 6'd59) ? 6'd0 : v + 6'd1;
        end else begin
            return (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
        end
    endfunction

    assign btn_raw_s = {btn_down, btn_up, btn_mode};

    // Synchronise, debounce and remember the previous debounced level per button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            deb_q      <= 3'b000;
            deb_prev_q <= 3'b000;
            db_cnt_q   <= '0;
        end else begin
            sync1_q    <= btn_raw_s;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    deb_q[i]    <= ~deb_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_ONE;
                end
            end
        end
    end

    // Press events; a step is dropped when it collides with mode or the opposite button.
    always_comb begin
        press_ev_s = deb_q & ~deb_prev_q;
        mode_ev_s  = press_ev_s[0];
        step_up_s  = press_ev_s[1] & ~press_ev_s[2] & ~mode_ev_s & (state_q != ST_RUN);
        step_dn_s  = press_ev_s[2] & ~press_ev_s[1] & ~mode_ev_s & (state_q != ST_RUN);
    end

`ifdef ALARM_SET_AUTOREPEAT_EN
    localparam int              RP_MAX        = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                                REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int              RP_W          = $clog2(RP_MAX + 1);
    localparam logic [RP_W-1:0] RP_DELAY_LAST = RP_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [RP_W-1:0] RP_RATE_LAST  = RP_W'(REPEAT_RATE_CYC - 1);
    localparam logic [RP_W-1:0] RP_ONE        = RP_W'(1);

    logic            rpt_act_q;
    logic            rpt_dir_up_q;
    logic            rpt_first_q;
    logic [RP_W-1:0] rpt_cnt_q;
    logic            rpt_held_s;
    logic            rpt_fire_s;

    // Repeat is only live while the arming button is held alone.
    always_comb begin
        rpt_held_s = rpt_dir_up_q ? (deb_q[1] & ~deb_q[2]) : (deb_q[2] & ~deb_q[1]);
        rpt_fire_s = rpt_act_q & rpt_held_s & ~mode_ev_s &
                     (rpt_cnt_q == (rpt_first_q ? RP_DELAY_LAST : RP_RATE_LAST));
        rpt_up_s   = rpt_fire_s & rpt_dir_up_q;
        rpt_dn_s   = rpt_fire_s & ~rpt_dir_up_q;
    end

    // Arm on an accepted press step; count delay then rate; disarm on mode/release/opposite.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_act_q    <= 1'b0;
            rpt_dir_up_q <= 1'b0;
            rpt_first_q  <= 1'b0;
            rpt_cnt_q    <= '0;
        end else if (mode_ev_s) begin
            rpt_act_q <= 1'b0;
        end else if (step_up_s || step_dn_s) begin
            rpt_act_q    <= 1'b1;
            rpt_dir_up_q <= step_up_s;
            rpt_first_q  <= 1'b1;
            rpt_cnt_q    <= '0;
        end else if (rpt_act_q) begin
            if (!rpt_held_s) begin
                rpt_act_q <= 1'b0;
            end else if (rpt_fire_s) begin
                rpt_first_q <= 1'b0;
                rpt_cnt_q   <= '0;
            end else begin
                rpt_cnt_q <= rpt_cnt_q + RP_ONE;
            end
        end
    end
`else
    assign rpt_up_s = 1'b0;
    assign rpt_dn_s = 1'b0;
`endif

    assign inc_s = step_up_s | rpt_up_s;
    assign dec_s = step_dn_s | rpt_dn_s;

    // Editor FSM with registered field values and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            hr_q       <= 5'(RST_HR);
            min_q      <= 6'(RST_MIN);
            edit_hr_q  <= 1'b0;
            edit_min_q <= 1'b0;
            valid_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mode_ev_s) begin
                        state_q   <= ST_SET_HR;
                        edit_hr_q <= 1'b1;
                        valid_q   <= 1'b0;
                    end
                end
                ST_SET_HR: begin
                    if (mode_ev_s) begin
                        state_q    <= ST_SET_MIN;
                        edit_hr_q  <= 1'b0;
                        edit_min_q <= 1'b1;
                    end else if (inc_s) begin
                        hr_q <= hr_step(hr_q, 1'b1);
                    end else if (dec_s) begin
                        hr_q <= hr_step(hr_q, 1'b0);
                    end
                end
                ST_SET_MIN: begin
                    if (mode_ev_s) begin
                        state_q    <= ST_RUN;
                        edit_min_q <= 1'b0;
                        valid_q    <= 1'b1;
                    end else if (inc_s) begin
                        min_q <= min_step(min_q, 1'b1);
                    end else if (dec_s) begin
                        min_q <= min_step(min_q, 1'b0);
                    end
                end
                default: begin
                    state_q    <= ST_RUN;
                    edit_hr_q  <= 1'b0;
                    edit_min_q <= 1'b0;
                    valid_q    <= 1'b1;
                end
            endcase
        end
    end

    assign alarm_hr    = hr_q;
    assign alarm_min   = min_q;
    assign edit_hr     = edit_hr_q;
    assign edit_min    = edit_min_q;
    assign alarm_valid = valid_q;

endmodule

// File: tb/tb_alarm_time_set.sv
// Directed self-checking bench for alarm_time_set with short debounce/repeat timing.
module tb_alarm_time_set;

    localparam logic [2:0] B_MODE = 3'b001;
    localparam logic [2:0] B_UP   = 3'b010;
    localparam logic [2:0] B_DOWN = 3'b100;

    logic       clk;
    logic       rst;
    logic [2:0] btns;
    logic [4:0] alarm_hr;
    logic [5:0] alarm_min;
    logic       edit_hr;
    logic       edit_min;
    logic       alarm_valid;

    int checks   = 0;
    int failures = 0;
    int exp_min  = 0;

    alarm_time_set #(
        .DEBOUNCE_CYC    (4),
        .REPEAT_DELAY_CYC(20),
        .REPEAT_RATE_CYC (5),
        .RST_HR          (7),
        .RST_MIN         (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btns[0]),
        .btn_up     (btns[1]),
        .btn_down   (btns[2]),
        .alarm_hr   (alarm_hr),
        .alarm_min  (alarm_min),
        .edit_hr    (edit_hr),
        .edit_min   (edit_min),
        .alarm_valid(alarm_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] mask, input int hold);
        btns = btns | mask;
        tick(hold);
        btns = btns & ~mask;
        tick(12);
    endtask

    initial begin
        rst  = 1'b1;
        btns = 3'b000;
        tick(2);
        rst = 1'b0;
        tick(1);
        check_eq("rst_hr", alarm_hr, 7);
        check_eq("rst_min", alarm_min, 0);
        check_eq("rst_valid", alarm_valid, 1);
        check_eq("rst_edit_hr", edit_hr, 0);
        check_eq("rst_edit_min", edit_min, 0);

        // 3-cycle glitch on mode is rejected
        press(B_MODE, 3);
        check_eq("glitch_valid", alarm_valid, 1);
        check_eq("glitch_edit_hr", edit_hr, 0);

        // 10-cycle mode press: state changes exactly 6 edges after first sample
        btns = B_MODE;
        tick(6);
        check_eq("lat_pre_valid", alarm_valid, 1);
        tick(1);
        check_eq("lat_valid", alarm_valid, 0);
        check_eq("lat_edit_hr", edit_hr, 1);
        tick(3);
        btns = 3'b000;
        tick(12);

        press(B_UP | B_DOWN, 10);
        check_eq("updown_hr", alarm_hr, 7);

        for (int i = 0; i < 7; i++) press(B_DOWN, 10);
        check_eq("hr_down_to0", alarm_hr, 0);
        press(B_DOWN, 10);
        check_eq("hr_wrap_down", alarm_hr, 23);
        press(B_UP, 10);
        check_eq("hr_wrap_up", alarm_hr, 0);
        for (int i = 0; i < 7; i++) press(B_UP, 10);
        check_eq("hr_back7", alarm_hr, 7);

        press(B_MODE | B_UP, 10);
        check_eq("modeup_edit_min", edit_min, 1);
        check_eq("modeup_edit_hr", edit_hr, 0);
        check_eq("modeup_hr", alarm_hr, 7);
        check_eq("modeup_min", alarm_min, 0);

        press(B_DOWN, 10);
        check_eq("min_wrap_down", alarm_min, 59);
        check_eq("min_edit_hr_kept", alarm_hr, 7);
        press(B_UP, 10);
        check_eq("min_wrap_up", alarm_min, 0);
        for (int i = 0; i < 10; i++) press(B_UP, 10);
        check_eq("min_ten", alarm_min, 10);

        // Long hold of up: press event, then repeat at +20, +25, +30, +35, +40
        btns = B_UP;
        tick(7);
        check_eq("hold_first_step", alarm_min, 11);
        tick(36);
        btns = 3'b000;
        tick(15);
`ifdef ALARM_SET_AUTOREPEAT_EN
        exp_min = 16;
`else
        exp_min = 11;
`endif
        check_eq("hold_min", alarm_min, exp_min);
        check_eq("hold_hr", alarm_hr, 7);

        while (exp_min != 42) begin
            press(B_UP, 10);
            exp_min++;
        end
        check_eq("min_42", alarm_min, 42);

        // Reset mid-edit with mode held: restores defaults, then mode re-debounces
        btns = B_MODE;
        rst  = 1'b1;
        tick(1);
        rst = 1'b0;
        check_eq("mid_rst_hr", alarm_hr, 7);
        check_eq("mid_rst_min", alarm_min, 0);
        check_eq("mid_rst_valid", alarm_valid, 1);
        check_eq("mid_rst_edit_min", edit_min, 0);
        tick(6);
        check_eq("held_pre_valid", alarm_valid, 1);
        tick(1);
        check_eq("held_valid", alarm_valid, 0);
        check_eq("held_edit_hr", edit_hr, 1);
        btns = 3'b000;
        tick(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
